// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and instruction memory (slave).
// Requests are held with a stable address until the memory answers with imem_ready.
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: owns the PC, runs the imem request/ready handshake and
// writes the IF/ID register under load-use stalls and branch redirects.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pc_load,
  input  logic          IF_ID_load,
  input  logic          branch_taken,
  input  logic [31:0]   branch_target,
  fetch_stage_if.master imem,
  output logic [31:0]   IF_ID_instr,
  output logic [31:0]   IF_ID_pc_plus4,
  output logic          IF_ID_valid
);

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    DISCARD
  } state_t;

  state_t      state;
  logic        req_active;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] discard_addr;
  logic [31:0] hold_instr;
  logic [31:0] hold_pc_plus4;
  logic        req;
  logic [31:0] addr;
  logic        completing;
  logic        left_open;
  logic        unused_target_bits;

  assign pc_plus4           = pc + 32'd4;
  assign completing         = req & imem.imem_ready;
  assign left_open          = req & ~imem.imem_ready;
  assign unused_target_bits = ^branch_target[1:0];

  // DISCARD keeps presenting the abandoned address until memory retires it.
  always_comb begin
    req  = 1'b0;
    addr = pc;
    case (state)
      FETCH:   req = req_active | pc_load;
      HOLD:    req = 1'b0;
      DISCARD: begin
        req  = 1'b1;
        addr = discard_addr;
      end
      default: req = 1'b0;
    endcase
    if (!rst_n) req = 1'b0;
  end

  assign imem.imem_req  = req;
  assign imem.imem_addr = addr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= FETCH;
      req_active     <= 1'b0;
      pc             <= RESET_PC;
      discard_addr   <= RESET_PC;
      hold_instr     <= NOP;
      hold_pc_plus4  <= 32'd0;
      IF_ID_instr    <= NOP;
      IF_ID_pc_plus4 <= 32'd0;
      IF_ID_valid    <= 1'b0;
    end else if (branch_taken) begin
      pc          <= {branch_target[31:2], 2'b00};
      req_active  <= 1'b0;
      IF_ID_instr <= NOP;
      IF_ID_valid <= 1'b0;
      if (left_open) begin
        state <= DISCARD;
        if (state != DISCARD) discard_addr <= pc;
      end else begin
        state <= FETCH;
      end
    end else begin
      case (state)
        FETCH: begin
          if (completing) begin
            pc         <= pc_plus4;
            req_active <= 1'b0;
            if (IF_ID_load) begin
              IF_ID_instr    <= imem.imem_rdata;
              IF_ID_pc_plus4 <= pc_plus4;
              IF_ID_valid    <= 1'b1;
            end else begin
              hold_instr    <= imem.imem_rdata;
              hold_pc_plus4 <= pc_plus4;
              state         <= HOLD;
            end
          end else begin
            req_active <= req;
            if (IF_ID_load) begin
              IF_ID_instr <= NOP;
              IF_ID_valid <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (IF_ID_load) begin
            IF_ID_instr    <= hold_instr;
            IF_ID_pc_plus4 <= hold_pc_plus4;
            IF_ID_valid    <= 1'b1;
            state          <= FETCH;
          end
        end
        DISCARD: begin
          if (imem.imem_ready) state <= FETCH;
          if (IF_ID_load) begin
            IF_ID_instr <= NOP;
            IF_ID_valid <= 1'b0;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule
